conway_frame_dump: RTL

//  Downstream consumer of the 64x64 next-generation board written by the cell-update engine.
//  On a start pulse, reads all 4096 1-bit cells from the board RAM read port in address order.

---
 rtl/conway_pkg.sv | 24 ++
 rtl/conway_bit_packer.sv | 38 +++
 rtl/conway_frame_dump.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conway_pkg.sv
// ============================================================================
// Module   : conway_pkg
// Purpose  : Shared board geometry constants and the frame-dump state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conway_pkg;

    localparam int BOARD_DIM   = 64;
    localparam int ADDR_W      = 12;
    localparam int FRAME_WORDS = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/conway_bit_packer.sv
// ============================================================================
// Module   : conway_bit_packer
// Purpose  : Packs serial 1-bit cells into a BYTE_W-bit word, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_bit_packer #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              din,
    output logic [BYTE_W-1:0] word
);

    localparam int IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            r_idx <= '0;
        end else if (clear) begin
            word  <= '0;
            r_idx <= '0;
        end else if (shift_en) begin
            word[r_idx] <= din;
            r_idx       <= r_idx + IDX_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/conway_frame_dump.sv
// ============================================================================
// Module   : conway_frame_dump
// Purpose  : Reads the 64x64 board RAM in address order and streams it as
//            packed words over valid/ready. Optional live-cell count is
//            enabled by defining CONWAY_DUMP_POPCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_frame_dump
    import conway_pkg::*;
#(
    parameter int ADDR_W = conway_pkg::ADDR_W,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr_rd,
    output logic              we_rd,
    input  logic              din,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef CONWAY_DUMP_POPCOUNT_EN
    ,
    output logic [ADDR_W:0]   pop_count
`endif
);

    localparam int                CNT_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(BYTE_W - 1);
    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(BYTE_W);

    dump_state_t       r_state;
    dump_state_t       w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_clear;
    logic              w_shift;
    logic              w_accept;
    logic              w_start;

    assign we_rd   = 1'b0;
    assign w_start = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_accept     = 1'b0;
        addr_rd      = '0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = FETCH;
                    w_clear      = 1'b1;
                end
            end
            FETCH: begin
                addr_rd = r_ptr + ADDR_W'(r_cnt);
                // RAM data lags the address by one cycle, so the first
                // fetch cycle has nothing to capture yet.
                w_shift = (r_cnt != '0);
                if (r_cnt == C_LAST) begin
                    w_next_state = CAPT;
                end
            end
            CAPT: begin
                w_shift      = 1'b1;
                w_next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_accept = 1'b1;
                    if (r_ptr != '0) begin
                        w_next_state = FETCH;
                        w_clear      = 1'b1;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_start) begin
                r_ptr <= '0;
            end else if (r_state == CAPT) begin
                r_ptr <= r_ptr + C_STEP;
            end
            if ((r_state == FETCH) && (r_cnt != C_LAST)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    conway_bit_packer #(
        .BYTE_W   (BYTE_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .shift_en (w_shift),
        .din      (din),
        .word     (out_data)
    );

`ifdef CONWAY_DUMP_POPCOUNT_EN
    logic [ADDR_W:0] r_live;

    // Published on the final acceptance so the total is visible during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live    <= '0;
            pop_count <= '0;
        end else begin
            if (w_start) begin
                r_live <= '0;
            end else if (w_shift && din) begin
                r_live <= r_live + (ADDR_W + 1)'(1);
            end
            if (w_accept && (r_ptr == '0)) begin
                pop_count <= r_live;
            end
        end
    end
`endif

endmodule

`default_nettype wire
